// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives an external program counter, reads instruction memory,
// and resolves jump/call/return/halt decisions with a small return-address stack.
module fetch_controller #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned STACK_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc_value,
   output logic [15:0] pc_next,
   output logic        pc_load,
   output logic        pc_ce,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        exec_done,
   input  logic        jump_req,
   input  logic        call_req,
   input  logic        ret_req,
   input  logic        halt_req,
   input  logic [15:0] jump_addr,
   output logic        halted,
   output logic        stack_err
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << IDX_W;

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      EXEC,
      HALT,
      ERROR
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [SP_W-1:0]   sp;
   logic [15:0]       stack [SLOTS];
   logic [15:0]       stack_top;
   logic              stack_empty;
   logic              stack_full;
   logic              push;
   logic              pop;
   logic              accept;

   assign stack_top   = stack[IDX_W'(sp - SP_W'(1))];
   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_next;
   end

   // Next state and combinational PC/memory controls
   always_comb begin
      state_next = state;
      pc_ce      = 1'b0;
      pc_load    = 1'b0;
      pc_next    = 16'h0000;
      mem_req    = 1'b0;
      mem_addr   = 16'h0000;
      push       = 1'b0;
      pop        = 1'b0;
      accept     = 1'b0;

      case (state)
         BOOT: begin
            pc_ce      = 1'b1;
            pc_load    = 1'b1;
            pc_next    = RESET_VECTOR;
            state_next = FETCH;
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_value;
            if (mem_ack) begin
               accept     = 1'b1;
               pc_ce      = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            // Priority: halt > ret > call > jump > sequential
            if (exec_done) begin
               if (halt_req) begin
                  state_next = HALT;
               end else if (ret_req) begin
                  if (stack_empty) begin
                     state_next = ERROR;
                  end else begin
                     pop        = 1'b1;
                     pc_ce      = 1'b1;
                     pc_load    = 1'b1;
                     pc_next    = stack_top;
                     state_next = FETCH;
                  end
               end else if (call_req) begin
                  if (stack_full) begin
                     state_next = ERROR;
                  end else begin
                     push       = 1'b1;
                     pc_ce      = 1'b1;
                     pc_load    = 1'b1;
                     pc_next    = jump_addr;
                     state_next = FETCH;
                  end
               end else if (jump_req) begin
                  pc_ce      = 1'b1;
                  pc_load    = 1'b1;
                  pc_next    = jump_addr;
                  state_next = FETCH;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         HALT:    state_next = HALT;
         ERROR:   state_next = ERROR;
         default: state_next = BOOT;
      endcase
   end

   // Registered status, instruction register and stack pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir        <= 16'h0000;
         ir_valid  <= 1'b0;
         halted    <= 1'b0;
         stack_err <= 1'b0;
         sp        <= '0;
      end else begin
         ir_valid  <= accept;
         halted    <= (state_next == HALT) || (state_next == ERROR);
         stack_err <= (state_next == ERROR);
         if (accept) ir <= mem_data;
         if (push)      sp <= sp + SP_W'(1);
         else if (pop)  sp <= sp - SP_W'(1);
      end
   end

   // Return-address storage; the pointer alone defines validity, so no reset is needed
   always_ff @(posedge clk) begin
      if (rst_n && push) stack[IDX_W'(sp)] <= pc_value;
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with an external PC register model.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc = 16'h1234;
   logic [15:0] pc_next;
   logic        pc_load, pc_ce, mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [15:0] ir;
   logic        ir_valid;
   logic        exec_done, jump_req, call_req, ret_req, halt_req;
   logic [15:0] jump_addr;
   logic        halted, stack_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Program counter as it would exist outside the controller
   always @(posedge clk) if (pc_ce) pc <= pc_load ? pc_next : pc + 16'd1;

   fetch_controller dut (
      .clk(clk), .rst_n(rst_n), .pc_value(pc), .pc_next(pc_next), .pc_load(pc_load),
      .pc_ce(pc_ce), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done),
      .jump_req(jump_req), .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
      .jump_addr(jump_addr), .halted(halted), .stack_err(stack_err)
   );

   typedef struct {
      logic        rst;
      logic        ack;
      logic [15:0] dat;
      logic        done;
      logic        hlt;
      logic        ret;
      logic        call;
      logic        jmp;
      logic [15:0] ja;
      logic        cpc;
      logic [15:0] epc;
      logic        emreq;
      logic [15:0] emaddr;
      logic        ece;
      logic        eld;
      logic [15:0] enxt;
      logic [15:0] eir;
      logic        eirv;
      logic        ehalt;
      logic        eserr;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_ack = 1'b0; mem_data = 16'h0000; exec_done = 1'b0; jump_req = 1'b0;
      call_req = 1'b0; ret_req = 1'b0; halt_req = 1'b0; jump_addr = 16'h0000;
   endtask

   // Leaves the DUT in its first FETCH cycle
   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic fetch(input logic [15:0] data);
      mem_ack = 1'b1; mem_data = data;
      tick();
      mem_ack = 1'b0;
   endtask

   task automatic exec(input logic h, input logic r, input logic c, input logic j,
                       input logic [15:0] a);
      exec_done = 1'b1; halt_req = h; ret_req = r; call_req = c; jump_req = j; jump_addr = a;
      tick();
      clear_inputs();
   endtask

   initial begin
      // rst ack  dat      done h r c j ja     | cpc pc     mreq maddr   ce ld nxt     ir       irv hl se
      tbl[0]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000, 1'b1,1'b1,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000, 1'b0,16'h0000, 1'b1,1'b1,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b1,16'hA5A5,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000, 1'b1,16'h0000, 1'b1,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[5]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0300, 1'b1,16'h0001, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'hA5A5,1'b1,1'b0,1'b0};
      tbl[6]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0100, 1'b1,16'h0001, 1'b0,16'h0000, 1'b1,1'b1,16'h0100, 16'hA5A5,1'b0,1'b0,1'b0};
      tbl[7]  = '{1'b1,1'b1,16'h1111,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0100, 1'b1,16'h0100, 1'b1,1'b0,16'h0000, 16'hA5A5,1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0101, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h1111,1'b1,1'b0,1'b0};
      tbl[9]  = '{1'b1,1'b1,16'h2222,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0101, 1'b1,16'h0101, 1'b1,1'b0,16'h0000, 16'h1111,1'b0,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b1,1'b0,16'h0200, 1'b1,16'h0102, 1'b0,16'h0000, 1'b1,1'b1,16'h0200, 16'h2222,1'b1,1'b0,1'b0};
      tbl[11] = '{1'b1,1'b1,16'h3333,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0200, 1'b1,16'h0200, 1'b1,1'b0,16'h0000, 16'h2222,1'b0,1'b0,1'b0};
      tbl[12] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b1,1'b1,1'b1,16'h0400, 1'b1,16'h0201, 1'b0,16'h0000, 1'b1,1'b1,16'h0102, 16'h3333,1'b1,1'b0,1'b0};
      tbl[13] = '{1'b1,1'b1,16'h4444,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0102, 1'b1,16'h0102, 1'b1,1'b0,16'h0000, 16'h3333,1'b0,1'b0,1'b0};
      tbl[14] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0103, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h4444,1'b1,1'b0,1'b0};
      tbl[15] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0103, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h4444,1'b0,1'b1,1'b1};
      tbl[16] = '{1'b1,1'b1,16'h5555,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0600, 1'b1,16'h0103, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h4444,1'b0,1'b1,1'b1};
      tbl[17] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0103, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h4444,1'b0,1'b1,1'b1};
      tbl[18] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0103, 1'b0,16'h0000, 1'b1,1'b1,16'h0000, 16'h0000,1'b0,1'b0,1'b0};
      tbl[19] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0,1'b0};

      clear_inputs();
      rst_n = 1'b0;
      tick(); tick();

      for (int i = 0; i < 20; i++) begin
         rst_n = tbl[i].rst; mem_ack = tbl[i].ack; mem_data = tbl[i].dat;
         exec_done = tbl[i].done; halt_req = tbl[i].hlt; ret_req = tbl[i].ret;
         call_req = tbl[i].call; jump_req = tbl[i].jmp; jump_addr = tbl[i].ja;
         #1;
         if (tbl[i].cpc) chk($sformatf("row%0d pc", i), pc, tbl[i].epc);
         chk($sformatf("row%0d mem_req", i),   16'(mem_req),   16'(tbl[i].emreq));
         chk($sformatf("row%0d mem_addr", i),  mem_addr,       tbl[i].emaddr);
         chk($sformatf("row%0d pc_ce", i),     16'(pc_ce),     16'(tbl[i].ece));
         chk($sformatf("row%0d pc_load", i),   16'(pc_load),   16'(tbl[i].eld));
         chk($sformatf("row%0d pc_next", i),   pc_next,        tbl[i].enxt);
         chk($sformatf("row%0d ir", i),        ir,             tbl[i].eir);
         chk($sformatf("row%0d ir_valid", i),  16'(ir_valid),  16'(tbl[i].eirv));
         chk($sformatf("row%0d halted", i),    16'(halted),    16'(tbl[i].ehalt));
         chk($sformatf("row%0d stack_err", i), 16'(stack_err), 16'(tbl[i].eserr));
         @(posedge clk);
         #0;
      end
      #1;

      // Call from 0005 returns to 0006; nested returns pop in LIFO order
      do_reset();
      fetch(16'h0001);
      exec(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
      fetch(16'h0002);
      chk("call_ret pc_before_call", pc, 16'h0006);
      exec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
      chk("call_ret pc_after_call", pc, 16'h0200);
      fetch(16'h0003);
      exec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0300);
      fetch(16'h0004);
      exec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0400);
      fetch(16'h0005);
      exec(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("call_ret ret1", pc, 16'h0301);
      fetch(16'h0006);
      exec(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("call_ret ret2", pc, 16'h0201);
      fetch(16'h0007);
      exec(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("call_ret ret3", pc, 16'h0006);
      chk("call_ret mem_addr", mem_addr, 16'h0006);
      chk("call_ret stack_err", 16'(stack_err), 16'h0000);

      // Fifth nested call with a four-entry stack
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         fetch(16'h00C0);
         exec(1'b0, 1'b0, 1'b1, 1'b0, 16'(k * 16));
      end
      chk("overflow pc_before", pc, 16'h0040);
      fetch(16'h00C0);
      exec_done = 1'b1; call_req = 1'b1; jump_addr = 16'h0050;
      #1;
      chk("overflow pc_ce", 16'(pc_ce), 16'h0000);
      tick();
      clear_inputs();
      #1;
      chk("overflow pc", pc, 16'h0041);
      chk("overflow halted", 16'(halted), 16'h0001);
      chk("overflow stack_err", 16'(stack_err), 16'h0001);
      chk("overflow mem_req", 16'(mem_req), 16'h0000);

      // Halt wins over simultaneous call/jump and stays parked
      do_reset();
      fetch(16'h0BAD);
      exec(1'b1, 1'b0, 1'b1, 1'b1, 16'h0700);
      chk("halt pc", pc, 16'h0001);
      chk("halt halted", 16'(halted), 16'h0001);
      chk("halt stack_err", 16'(stack_err), 16'h0000);
      mem_ack = 1'b1; exec_done = 1'b1; jump_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("halt mem_req%0d", k), 16'(mem_req), 16'h0000);
         chk($sformatf("halt pc_ce%0d", k), 16'(pc_ce), 16'h0000);
         tick();
      end
      clear_inputs();

      // Reset during an acknowledged fetch discards the instruction
      do_reset();
      fetch(16'h1234);
      exec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk("midreset ir_before", ir, 16'h1234);
      mem_ack = 1'b1; mem_data = 16'hBEEF; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; clear_inputs();
      #1;
      chk("midreset ir", ir, 16'h0000);
      chk("midreset ir_valid", 16'(ir_valid), 16'h0000);
      chk("midreset boot_load", 16'(pc_load), 16'h0001);
      chk("midreset boot_next", pc_next, 16'h0000);
      chk("midreset mem_req", 16'(mem_req), 16'h0000);
      tick();
      chk("midreset pc", pc, 16'h0000);
      chk("midreset fetch_req", 16'(mem_req), 16'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000, the PC value loaded after reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, the number of return-address entries (1..8).
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port pc_value  in  16  current program counter output.
REQ-006 SHALL have ports pc_next  out  16, pc_load  out  1, pc_ce  out  1  driving program counter IN/load/CE.
REQ-007 SHALL have ports mem_req  out  1, mem_addr  out  16, mem_ack  in  1, mem_data  in  16  for instruction-memory read.
REQ-008 SHALL have ports ir  out  16 (instruction register) and ir_valid  out  1 (one-cycle new-instruction pulse).
REQ-009 SHALL have inputs exec_done, jump_req, call_req, ret_req, halt_req (1 each) and jump_addr  in  16.
REQ-010 SHALL have outputs halted  out  1 and stack_err  out  1.

Function
REQ-011 SHALL implement the FSM states BOOT, FETCH, EXEC, HALT, ERROR.
REQ-012 In BOOT: pc_ce=1, pc_load=1, pc_next=RESET_VECTOR; next state FETCH unconditionally.
REQ-013 In FETCH: mem_req=1, mem_addr=pc_value; hold until mem_ack=1 (no timeout).
REQ-014 On the FETCH cycle with mem_ack=1: ir<=mem_data, ir_valid<=1 next cycle, pc_ce=1 with pc_load=0 (increment); next state EXEC.
REQ-015 ir_valid SHALL be high for exactly one cycle per accepted fetch; ir SHALL hold its value until the next accepted fetch.
REQ-016 In EXEC: pc_ce=0 and mem_req=0 until exec_done=1; control requests SHALL be ignored while exec_done=0.
REQ-017 On the EXEC cycle with exec_done=1, decisions SHALL use fixed priority halt_req > ret_req > call_req > jump_req > sequential.
REQ-018 halt: next state HALT; PC untouched.
REQ-019 ret, stack non-empty: pop; pc_next=popped entry, pc_ce=1, pc_load=1; next FETCH.
REQ-020 ret, stack empty: no PC change; stack_err<=1; next ERROR.
REQ-021 call, stack not full: push pc_value (already the incremented return address); pc_next=jump_addr, pc_ce=1, pc_load=1; next FETCH.
REQ-022 call, stack full (STACK_DEPTH entries): no push, no PC change; stack_err<=1; next ERROR.
REQ-023 jump: pc_next=jump_addr, pc_ce=1, pc_load=1; stack unchanged; next FETCH.
REQ-024 sequential (no request): pc_ce=0; next FETCH.
REQ-025 In HALT: halted=1, pc_ce=0, mem_req=0; exit only via reset.
REQ-026 In ERROR: halted=1, stack_err=1, pc_ce=0, mem_req=0; exit only via reset.
REQ-027 pc_ce, pc_load, pc_next, mem_req, mem_addr SHALL be combinational from state and inputs; pc_next=16'h0000 and pc_load=0 whenever pc_ce=0.
REQ-028 Stack push/pop SHALL update the stack pointer on the same edge as the PC load; PC address arithmetic wraps modulo 2^16 in the program counter (16'hFFFF+1=16'h0000), not in this block.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state BOOT, stack pointer 0, ir=16'h0000, ir_valid=0, halted=0, stack_err=0.
REQ-030 Reset SHALL take precedence over every state, including mid-fetch (mem_ack ignored) and HALT/ERROR.
REQ-031 First cycle after rst_n returns high SHALL be BOOT (PC loaded with RESET_VECTOR); first mem_req one cycle later.

Verification
REQ-032 Boot/fetch: release reset, mem_ack after 2 wait cycles with mem_data=16'hA5A5 -> PC=0000 then 0001, ir=A5A5, one ir_valid pulse, mem_addr=0000 throughout wait.
REQ-033 Jump: exec_done+jump_req with jump_addr=16'h0100 -> PC=0100, next mem_addr=0100, stack unchanged.
REQ-034 Call/return: at PC=0005 fetch (PC becomes 0006), call to 0200, later ret -> PC=0006; call+ret+jump same cycle -> ret taken.
REQ-035 Stack limits: 5 nested calls with STACK_DEPTH=4 -> 5th gives stack_err=1, halted=1, PC unchanged; ret from reset -> ERROR.
REQ-036 Halt and reset: halt_req -> halted=1, no further mem_req; rst_n=0 during FETCH with mem_ack=1 -> ir stays 0000, state BOOT, PC reloaded to RESET_VECTOR.
